dvp_tx: RTL



---
 rtl/dvp_tx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dvp_tx.sv
// DVP camera-port transmitter: RGB565 valid/ready stream in, vsync/href/byte bus out.
// Defining DVP_TX_TEST_PATTERN_EN adds the test_mode input and an 8-bar colour generator.
module dvp_tx #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned VSYNC_LINES = 4,
    parameter int unsigned V_BACK      = 16,
    parameter int unsigned V_FRONT     = 8
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        pix_ready,
    output logic        dvp_pclk,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_busy,
    output logic        underflow
);

    localparam int unsigned LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW          = $clog2(LINE_LEN + 1);
    localparam int unsigned VMAX_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int unsigned VMAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned VMAX        = (VMAX_A > VMAX_B) ? VMAX_A : VMAX_B;
    localparam int unsigned VW          = (VMAX < 2) ? 1 : $clog2(VMAX);
    localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_PIX     = HW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [7:0]    low_byte;
    logic          in_line, act_line, slot, h_last, v_last, adv, start;
    logic [15:0]   src;
    logic          src_ok;

    function automatic int unsigned lines_of(state_t s);
        case (s)
            VSYNC:   return VSYNC_LINES;
            VBACK:   return V_BACK;
            ACTIVE:  return V_ACTIVE;
            VFRONT:  return V_FRONT;
            default: return 0;
        endcase
    endfunction

    // State that follows s once s completes, stepping over states with zero lines.
    function automatic state_t follow(state_t s, logic en);
        state_t n;
        n = s;
        for (int unsigned i = 0; i < 4; i++) begin
            case (n)
                VSYNC:   n = VBACK;
                VBACK:   n = ACTIVE;
                ACTIVE:  n = VFRONT;
                default: n = en ? VSYNC : IDLE;
            endcase
            if (n == IDLE || lines_of(n) != 0)
                return n;
        end
        return IDLE;
    endfunction

`ifdef DVP_TX_TEST_PATTERN_EN
    logic tm;

    function automatic logic [15:0] bar_colour(logic [HW-1:0] h);
        int unsigned x;
        logic [2:0]  idx;
        x   = 32'(h) >> 1;
        idx = 3'((x * 8) / H_ACTIVE);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction
`endif

    assign dvp_pclk = clk;

    always_comb begin
        in_line  = h_cnt < H_PIX;
        act_line = state == ACTIVE;
        slot     = act_line && in_line && !h_cnt[0];
        h_last   = h_cnt == H_LAST;
        v_last   = v_cnt == VW'(lines_of(state) - 1);
        adv      = (state == IDLE) ? enable : (h_last && v_last);
        nxt      = follow(state, enable);
        // A move backwards (or same state) through the sequence means a new frame begins.
        start    = adv && nxt != IDLE && (state == IDLE || nxt <= state);
`ifdef DVP_TX_TEST_PATTERN_EN
        src       = tm ? bar_colour(h_cnt) : pix_data;
        src_ok    = tm || pix_valid;
        pix_ready = slot && !tm;
`else
        src       = pix_data;
        src_ok    = pix_valid;
        pix_ready = slot;
`endif
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state      <= IDLE;
            h_cnt      <= '0;
            v_cnt      <= '0;
            low_byte   <= '0;
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= '0;
            frame_busy <= 1'b0;
            underflow  <= 1'b0;
`ifdef DVP_TX_TEST_PATTERN_EN
            tm         <= 1'b0;
`endif
        end else begin
            if (adv) begin
                state <= nxt;
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (state != IDLE) begin
                h_cnt <= h_last ? '0 : h_cnt + HW'(1);
                if (h_last)
                    v_cnt <= v_cnt + VW'(1);
            end

            dvp_vsync  <= state == VSYNC;
            dvp_href   <= act_line && in_line;
            frame_busy <= state != IDLE;

            if (slot) begin
                dvp_data <= src_ok ? src[15:8] : 8'h00;
                low_byte <= src_ok ? src[7:0] : 8'h00;
                if (!src_ok)
                    underflow <= 1'b1;
            end else if (act_line && in_line) begin
                dvp_data <= low_byte;
            end else begin
                dvp_data <= '0;
            end

            if (start) begin
                underflow <= 1'b0;
`ifdef DVP_TX_TEST_PATTERN_EN
                tm        <= test_mode;
`endif
            end
        end
    end

endmodule
